// File: rtl/code_entry_unit.sv
// Keypad front end for the combination lock: collects digits, compares them with the stored code
// and turns the enter/change button levels into single-cycle pulses for the lock FSM.
module code_entry_unit #(
    parameter int unsigned                   DIGITS       = 4,
    parameter int unsigned                   DIGIT_W      = 4,
    parameter logic [DIGITS*DIGIT_W-1:0]     DEFAULT_CODE = 16'h1234
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic [DIGIT_W-1:0]               digit,
    input  logic                             digit_valid,
    input  logic                             enter_btn,
    input  logic                             change_btn,
    input  logic                             clear,
    input  logic                             new_mode,
    output logic                             enter,
    output logic                             change,
    output logic                             correct,
    output logic [$clog2(DIGITS+1)-1:0]      count,
    output logic                             code_saved
);

    localparam int unsigned CODE_W  = DIGITS * DIGIT_W;
    localparam int unsigned COUNT_W = $clog2(DIGITS + 1);

    localparam logic [COUNT_W-1:0] FULL_COUNT = COUNT_W'(DIGITS);
    localparam logic [DIGIT_W-1:0] MAX_DIGIT  = DIGIT_W'(9);

    logic [CODE_W-1:0]  buffer_q, buffer_d;
    logic [CODE_W-1:0]  code_q, code_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic               enter_btn_q, change_btn_q;
    logic               enter_q, enter_d;
    logic               change_q, change_d;
    logic               code_saved_q, code_saved_d;

    logic full;
    logic enter_rise;
    logic change_rise;
    logic digit_accept;

    assign full = (count_q == FULL_COUNT);

    always_comb begin
        enter_rise   = enter_btn & ~enter_btn_q;
        change_rise  = change_btn & ~change_btn_q;
        // Simultaneous rises resolve to enter only.
        enter_d      = enter_rise;
        change_d     = change_rise & ~enter_rise;

        digit_accept = digit_valid & (digit <= MAX_DIGIT) & ~full
                     & ~enter_q & ~change_q & ~clear;

        buffer_d     = buffer_q;
        count_d      = count_q;
        code_d       = code_q;
        code_saved_d = 1'b0;

        if (enter_q || change_q) begin
            // Every pulse cycle consumes the entry, matched or not.
            buffer_d = '0;
            count_d  = '0;
            if (enter_q && new_mode && full) begin
                code_d       = buffer_q;
                code_saved_d = 1'b1;
            end
        end else if (clear) begin
            buffer_d = '0;
            count_d  = '0;
        end else if (digit_accept) begin
            buffer_d = (buffer_q << DIGIT_W) | {{(CODE_W - DIGIT_W){1'b0}}, digit};
            count_d  = count_q + COUNT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            buffer_q     <= '0;
            count_q      <= '0;
            code_q       <= DEFAULT_CODE;
            enter_q      <= 1'b0;
            change_q     <= 1'b0;
            code_saved_q <= 1'b0;
            // Buttons held through reset must be released before they can pulse.
            enter_btn_q  <= 1'b1;
            change_btn_q <= 1'b1;
        end else begin
            buffer_q     <= buffer_d;
            count_q      <= count_d;
            code_q       <= code_d;
            enter_q      <= enter_d;
            change_q     <= change_d;
            code_saved_q <= code_saved_d;
            enter_btn_q  <= enter_btn;
            change_btn_q <= change_btn;
        end
    end

    assign enter      = enter_q;
    assign change     = change_q;
    assign count      = count_q;
    assign code_saved = code_saved_q;
    assign correct    = full & (buffer_q == code_q) & ~new_mode;

endmodule

// File: tb/tb_code_entry_unit.sv
// Table-driven bench for code_entry_unit with hand-written reset and held-button sequences.
module tb_code_entry_unit;

    logic       clock = 1'b0;
    logic       reset;
    logic [3:0] digit;
    logic       digit_valid;
    logic       enter_btn;
    logic       change_btn;
    logic       clear;
    logic       new_mode;
    logic       enter;
    logic       change;
    logic       correct;
    logic [2:0] count;
    logic       code_saved;

    code_entry_unit dut (
        .clock       (clock),
        .reset       (reset),
        .digit       (digit),
        .digit_valid (digit_valid),
        .enter_btn   (enter_btn),
        .change_btn  (change_btn),
        .clear       (clear),
        .new_mode    (new_mode),
        .enter       (enter),
        .change      (change),
        .correct     (correct),
        .count       (count),
        .code_saved  (code_saved)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic       v;
        logic [3:0] d;
        logic       eb;
        logic       cb;
        logic       clr;
        logic       nm;
        logic       en;
        logic       ch;
        logic       cor;
        logic [2:0] cnt;
        logic       sv;
    } vec_t;

    vec_t vecs[$];
    int   vectors = 0;
    int   miscompares = 0;

    task automatic add(input logic v, input logic [3:0] d, input logic eb, input logic cb,
                       input logic clr, input logic nm, input logic en, input logic ch,
                       input logic cor, input logic [2:0] cnt, input logic sv);
        vec_t x;
        x = '{v: v, d: d, eb: eb, cb: cb, clr: clr, nm: nm,
              en: en, ch: ch, cor: cor, cnt: cnt, sv: sv};
        vecs.push_back(x);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Outputs packed as {enter, change, correct, count, code_saved}.
    task automatic check(input string name, input logic [6:0] exp);
        logic [6:0] got;
        got = {enter, change, correct, count, code_saved};
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got en/ch/cor/cnt/sv=%b/%b/%b/%0d/%b, want %b/%b/%b/%0d/%b",
                     name, got[6], got[5], got[4], got[3:1], got[0],
                     exp[6], exp[5], exp[4], exp[3:1], exp[0]);
        end
    endtask

    task automatic drive(input logic v, input logic [3:0] d, input logic eb, input logic cb,
                         input logic clr, input logic nm);
        digit_valid = v;
        digit       = d;
        enter_btn   = eb;
        change_btn  = cb;
        clear       = clr;
        new_mode    = nm;
    endtask

    initial begin
        int pulses;
        int first_at;

        //  v  d     eb cb cl nm | en ch cor cnt sv
        // Correct code, enter held for two cycles.
        add(1, 4'd1, 0, 0, 0, 0,   0, 0, 0, 3'd1, 0);
        add(1, 4'd2, 0, 0, 0, 0,   0, 0, 0, 3'd2, 0);
        add(1, 4'd3, 0, 0, 0, 0,   0, 0, 0, 3'd3, 0);
        add(1, 4'd4, 0, 0, 0, 0,   0, 0, 1, 3'd4, 0);
        add(0, 4'd0, 1, 0, 0, 0,   1, 0, 1, 3'd4, 0);
        add(0, 4'd0, 1, 0, 0, 0,   0, 0, 0, 3'd0, 0);
        add(0, 4'd0, 0, 0, 0, 0,   0, 0, 0, 3'd0, 0);
        // Wrong code 1235.
        add(1, 4'd1, 0, 0, 0, 0,   0, 0, 0, 3'd1, 0);
        add(1, 4'd2, 0, 0, 0, 0,   0, 0, 0, 3'd2, 0);
        add(1, 4'd3, 0, 0, 0, 0,   0, 0, 0, 3'd3, 0);
        add(1, 4'd5, 0, 0, 0, 0,   0, 0, 0, 3'd4, 0);
        add(0, 4'd0, 1, 0, 0, 0,   1, 0, 0, 3'd4, 0);
        add(0, 4'd0, 0, 0, 0, 0,   0, 0, 0, 3'd0, 0);
        // Short entry 123.
        add(1, 4'd1, 0, 0, 0, 0,   0, 0, 0, 3'd1, 0);
        add(1, 4'd2, 0, 0, 0, 0,   0, 0, 0, 3'd2, 0);
        add(1, 4'd3, 0, 0, 0, 0,   0, 0, 0, 3'd3, 0);
        add(0, 4'd0, 1, 0, 0, 0,   1, 0, 0, 3'd3, 0);
        add(0, 4'd0, 0, 0, 0, 0,   0, 0, 0, 3'd0, 0);
        // Overflow digit 9 and illegal B are dropped.
        add(1, 4'd1, 0, 0, 0, 0,   0, 0, 0, 3'd1, 0);
        add(1, 4'd2, 0, 0, 0, 0,   0, 0, 0, 3'd2, 0);
        add(1, 4'd3, 0, 0, 0, 0,   0, 0, 0, 3'd3, 0);
        add(1, 4'd4, 0, 0, 0, 0,   0, 0, 1, 3'd4, 0);
        add(1, 4'd9, 0, 0, 0, 0,   0, 0, 1, 3'd4, 0);
        add(1, 4'hB, 0, 0, 0, 0,   0, 0, 1, 3'd4, 0);
        add(0, 4'd0, 1, 0, 0, 0,   1, 0, 1, 3'd4, 0);
        add(0, 4'd0, 0, 0, 0, 0,   0, 0, 0, 3'd0, 0);
        add(1, 4'hA, 0, 0, 0, 0,   0, 0, 0, 3'd0, 0);
        // New code 9876 in new_mode.
        add(1, 4'd9, 0, 0, 0, 1,   0, 0, 0, 3'd1, 0);
        add(1, 4'd8, 0, 0, 0, 1,   0, 0, 0, 3'd2, 0);
        add(1, 4'd7, 0, 0, 0, 1,   0, 0, 0, 3'd3, 0);
        add(1, 4'd6, 0, 0, 0, 1,   0, 0, 0, 3'd4, 0);
        add(0, 4'd0, 1, 0, 0, 1,   1, 0, 0, 3'd4, 0);
        add(0, 4'd0, 0, 0, 0, 1,   0, 0, 0, 3'd0, 1);
        add(0, 4'd0, 0, 0, 0, 0,   0, 0, 0, 3'd0, 0);
        // Old code now rejected.
        add(1, 4'd1, 0, 0, 0, 0,   0, 0, 0, 3'd1, 0);
        add(1, 4'd2, 0, 0, 0, 0,   0, 0, 0, 3'd2, 0);
        add(1, 4'd3, 0, 0, 0, 0,   0, 0, 0, 3'd3, 0);
        add(1, 4'd4, 0, 0, 0, 0,   0, 0, 0, 3'd4, 0);
        add(0, 4'd0, 1, 0, 0, 0,   1, 0, 0, 3'd4, 0);
        add(0, 4'd0, 0, 0, 0, 0,   0, 0, 0, 3'd0, 0);
        // New code accepted.
        add(1, 4'd9, 0, 0, 0, 0,   0, 0, 0, 3'd1, 0);
        add(1, 4'd8, 0, 0, 0, 0,   0, 0, 0, 3'd2, 0);
        add(1, 4'd7, 0, 0, 0, 0,   0, 0, 0, 3'd3, 0);
        add(1, 4'd6, 0, 0, 0, 0,   0, 0, 1, 3'd4, 0);
        add(0, 4'd0, 1, 0, 0, 0,   1, 0, 1, 3'd4, 0);
        add(0, 4'd0, 0, 0, 0, 0,   0, 0, 0, 3'd0, 0);
        // Both buttons rise together: enter only.
        add(0, 4'd0, 1, 1, 0, 0,   1, 0, 0, 3'd0, 0);
        add(0, 4'd0, 1, 1, 0, 0,   0, 0, 0, 3'd0, 0);
        add(0, 4'd0, 0, 0, 0, 0,   0, 0, 0, 3'd0, 0);
        // Change alone clears the entry.
        add(1, 4'd5, 0, 0, 0, 0,   0, 0, 0, 3'd1, 0);
        add(0, 4'd0, 0, 1, 0, 0,   0, 1, 0, 3'd1, 0);
        add(0, 4'd0, 0, 0, 0, 0,   0, 0, 0, 3'd0, 0);
        // Digit offered during the enter pulse is dropped.
        add(1, 4'd1, 0, 0, 0, 0,   0, 0, 0, 3'd1, 0);
        add(0, 4'd0, 1, 0, 0, 0,   1, 0, 0, 3'd1, 0);
        add(1, 4'd2, 0, 0, 0, 0,   0, 0, 0, 3'd0, 0);
        add(0, 4'd0, 0, 0, 0, 0,   0, 0, 0, 3'd0, 0);
        // Clear beats a simultaneous digit.
        add(1, 4'd3, 0, 0, 0, 0,   0, 0, 0, 3'd1, 0);
        add(1, 4'd4, 0, 0, 1, 0,   0, 0, 0, 3'd0, 0);
        add(0, 4'd0, 0, 0, 0, 0,   0, 0, 0, 3'd0, 0);
        // Clear a full matching entry.
        add(1, 4'd9, 0, 0, 0, 0,   0, 0, 0, 3'd1, 0);
        add(1, 4'd8, 0, 0, 0, 0,   0, 0, 0, 3'd2, 0);
        add(1, 4'd7, 0, 0, 0, 0,   0, 0, 0, 3'd3, 0);
        add(1, 4'd6, 0, 0, 0, 0,   0, 0, 1, 3'd4, 0);
        add(0, 4'd0, 0, 0, 1, 0,   0, 0, 0, 3'd0, 0);
        // Short entry confirmed in new_mode: no store.
        add(1, 4'd1, 0, 0, 0, 1,   0, 0, 0, 3'd1, 0);
        add(0, 4'd0, 1, 0, 0, 1,   1, 0, 0, 3'd1, 0);
        add(0, 4'd0, 0, 0, 0, 1,   0, 0, 0, 3'd0, 0);
        add(0, 4'd0, 0, 0, 0, 0,   0, 0, 0, 3'd0, 0);
        // Matching entry reads correct only outside new_mode; change abandons it.
        add(1, 4'd9, 0, 0, 0, 0,   0, 0, 0, 3'd1, 0);
        add(1, 4'd8, 0, 0, 0, 0,   0, 0, 0, 3'd2, 0);
        add(1, 4'd7, 0, 0, 0, 0,   0, 0, 0, 3'd3, 0);
        add(1, 4'd6, 0, 0, 0, 0,   0, 0, 1, 3'd4, 0);
        add(0, 4'd0, 0, 0, 0, 1,   0, 0, 0, 3'd4, 0);
        add(0, 4'd0, 0, 1, 0, 1,   0, 1, 0, 3'd4, 0);
        add(0, 4'd0, 0, 0, 0, 1,   0, 0, 0, 3'd0, 0);
        add(0, 4'd0, 0, 0, 0, 0,   0, 0, 0, 3'd0, 0);
        // Stored code still 9876.
        add(1, 4'd9, 0, 0, 0, 0,   0, 0, 0, 3'd1, 0);
        add(1, 4'd8, 0, 0, 0, 0,   0, 0, 0, 3'd2, 0);
        add(1, 4'd7, 0, 0, 0, 0,   0, 0, 0, 3'd3, 0);
        add(1, 4'd6, 0, 0, 0, 0,   0, 0, 1, 3'd4, 0);
        add(0, 4'd0, 1, 0, 0, 0,   1, 0, 1, 3'd4, 0);
        add(0, 4'd0, 0, 0, 0, 0,   0, 0, 0, 3'd0, 0);

        reset = 1'b1;
        drive(0, 4'd0, 0, 0, 0, 0);
        tick();
        tick();
        check("reset_state", 7'b0);
        reset = 1'b0;
        tick();
        check("post_reset_idle", 7'b0);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].v, vecs[i].d, vecs[i].eb, vecs[i].cb, vecs[i].clr, vecs[i].nm);
            tick();
            check($sformatf("vec%0d", i),
                  {vecs[i].en, vecs[i].ch, vecs[i].cor, vecs[i].cnt, vecs[i].sv});
        end

        // Enter held for ten cycles gives one pulse, right after the rise.
        drive(0, 4'd0, 0, 0, 0, 0);
        tick();
        pulses   = 0;
        first_at = -1;
        enter_btn = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (enter === 1'b1) begin
                pulses++;
                if (first_at < 0) first_at = i;
            end
        end
        vectors++;
        if (pulses != 1 || first_at != 0) begin
            miscompares++;
            $display("FAIL held_enter: got %0d pulses first at %0d, want 1 pulse at 0",
                     pulses, first_at);
        end
        enter_btn = 1'b0;
        tick();

        // Reset mid-entry with buttons held: entry lost, code back to 1234, no pulses.
        for (int i = 1; i <= 3; i++) begin
            drive(1, 4'(i), 0, 0, 0, 0);
            tick();
        end
        check("pre_reset_count3", 7'b000_011_0);
        reset = 1'b1;
        drive(0, 4'd0, 1, 1, 0, 0);
        tick();
        check("reset_mid_entry", 7'b0);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("held_through_reset%0d", i), 7'b0);
        end
        for (int i = 1; i <= 4; i++) begin
            drive(1, 4'(i), 1, 1, 0, 0);
            tick();
        end
        check("default_code_back", 7'b001_100_0);
        drive(0, 4'd0, 0, 1, 0, 0);
        tick();
        check("enter_released", 7'b001_100_0);
        enter_btn = 1'b1;
        tick();
        check("enter_repressed", 7'b101_100_0);
        drive(0, 4'd0, 0, 0, 0, 0);
        tick();
        check("after_enter_clear", 7'b0);
        change_btn = 1'b1;
        tick();
        check("change_repressed", 7'b010_000_0);
        change_btn = 1'b0;
        tick();
        check("final_idle", 7'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
